// File: rtl/sync_fifo_stream_reader_if.sv
// Handshake bundle between the FIFO read port, the stream reader and its
// downstream consumer.
//   fifo_ren    : pop strobe to the FIFO (reader -> FIFO)
//   fifo_rdata  : FIFO head word, combinational, valid when fifo_rempty=0
//   fifo_rempty : FIFO empty flag
//   flush       : single-cycle request to close the current partial beat
//   m_valid/m_ready/m_data/m_keep/m_last : packed output stream
// master = the stream reader, slave = the surrounding environment.
interface sync_fifo_stream_reader_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RATIO      = 4
);
  logic                          fifo_ren;
  logic [DATA_WIDTH-1:0]         fifo_rdata;
  logic                          fifo_rempty;
  logic                          flush;
  logic                          m_valid;
  logic                          m_ready;
  logic [RATIO*DATA_WIDTH-1:0]   m_data;
  logic [RATIO-1:0]              m_keep;
  logic                          m_last;

  modport master (
    output fifo_ren, m_valid, m_data, m_keep, m_last,
    input  fifo_rdata, fifo_rempty, flush, m_ready
  );

  modport slave (
    input  fifo_ren, m_valid, m_data, m_keep, m_last,
    output fifo_rdata, fifo_rempty, flush, m_ready
  );
endinterface

// File: rtl/sync_fifo_stream_reader.sv
// Read-side drain engine: pops words from a synchronous FIFO, packs RATIO
// consecutive words into one wide beat (first word in lane 0) and presents
// it on a registered valid/ready stream. A flush closes out a partial beat
// with a contiguous lane-keep mask and m_last set.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : sync_fifo_stream_reader_if master modport (FIFO read port,
//             flush request and output stream)
// The bus interface must be instantiated with the same DATA_WIDTH/RATIO.
module sync_fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RATIO      = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  sync_fifo_stream_reader_if.master  bus
);

  localparam int unsigned CW = $clog2(RATIO);
  localparam int unsigned BW = RATIO * DATA_WIDTH;
  localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

  logic [RATIO-2:0][DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic                             pend_q, pend_d;
  logic                             valid_q, valid_d;
  logic [BW-1:0]                    data_q, data_d;
  logic [RATIO-1:0]                 keep_q, keep_d;
  logic                             last_q, last_d;

  logic out_free;
  logic pop;
  logic complete;

  assign out_free = !valid_q || bus.m_ready;
  // The final lane may only be taken when the output register can accept
  // the finished beat on the same edge; earlier lanes gather freely.
  assign pop      = reset_n && !bus.fifo_rempty && !pend_q &&
                    ((cnt_q != LAST_LANE) || out_free);
  assign complete = pop && (cnt_q == LAST_LANE);

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    valid_d = valid_q && !bus.m_ready;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;

    if (pop) begin
      if (complete) begin
        data_d  = {bus.fifo_rdata, acc_q};
        keep_d  = '1;
        last_d  = bus.flush;
        valid_d = 1'b1;
        cnt_d   = '0;
      end else begin
        acc_d[cnt_q] = bus.fifo_rdata;
        cnt_d        = cnt_q + CW'(1);
      end
    end

    if (pend_q) begin
      // Pops are blocked while pending, so this never races a gather.
      // Any flush arriving now is absorbed into the one being resolved.
      if (out_free) begin
        pend_d = 1'b0;
        if (cnt_q != '0) begin
          data_d = '0;
          keep_d = '0;
          for (int unsigned i = 0; i < RATIO - 1; i++) begin
            if (CW'(i) < cnt_q) begin
              data_d[i*DATA_WIDTH +: DATA_WIDTH] = acc_q[i];
              keep_d[i] = 1'b1;
            end
          end
          last_d  = 1'b1;
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end
    end else if (bus.flush && !complete) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end

  assign bus.fifo_ren = pop;
  assign bus.m_valid  = valid_q;
  assign bus.m_data   = data_q;
  assign bus.m_keep   = keep_q;
  assign bus.m_last   = last_q;

endmodule
